inst_load_rx: RTL and testbench
===============================

Name: inst_load_rx

Overview:
- Receiving end of the instruction-load interface (Inst_addr_load / Inst_load / load_en) that drives the core's program image before reset release.
- Holds the instruction RAM and accepts word writes on the load port.
- Tracks load statistics (word count, checksum, error flag) and generates the core reset: asserted while loading, released a fixed settle time after the load ends.
- Serves instruction fetch from the core on a registered read port.

Parameters:
DEPTH, 256, number of 32-bit instruction words; power of two
AW, 32, byte-address width of load and fetch ports
SETTLE_CYCLES, 2, idle cycles after load_en falls before core reset releases; range 1..255

Ports:
clk  input  1  system clock
rst_n_mem  input  1  asynchronous active-low reset of memory/loader domain
Inst_addr_load  input  AW  byte address of word being loaded
Inst_load  input  32  instruction word being loaded
load_en  input  1  write strobe; one word per cycle while high
Inst_addr  input  AW  core fetch byte address
Inst  output  32  fetched instruction, valid one cycle after Inst_addr
core_rst_n  output  1  active-low reset to core; low until load complete and settled
load_done  output  1  high in RUN state
load_err  output  1  sticky; set on misaligned or out-of-range load address
word_cnt  output  $clog2(DEPTH)+1  number of accepted load writes since last load start
checksum  output  32  modulo-2^32 sum of accepted Inst_load words

Behaviour:
- Reset (rst_n_mem low, async): state IDLE; core_rst_n=0, load_done=0, load_err=0, word_cnt=0, checksum=0, Inst=0. RAM contents not cleared.
- Accepted write: load_en=1, Inst_addr_load[1:0]==0, Inst_addr_load>>2 < DEPTH. RAM[Inst_addr_load>>2] <= Inst_load on that clk edge; word_cnt += 1 (saturating at DEPTH); checksum += Inst_load (wraps).
- Rejected write (misaligned or out of range): no RAM write, no count/checksum update; load_err <= 1 (sticky until reset or new load start).
- Duplicate address writes are both accepted and both counted; last write wins in RAM.
- States:
  - IDLE: wait for load_en. On load_en -> LOADING; word_cnt, checksum, and load_err restart from this first write (first word already counted).
  - LOADING: core_rst_n=0. load_en low for one cycle -> SETTLE with counter=0.
  - SETTLE: core_rst_n=0. load_en high -> back to LOADING, counters retained (gap tolerance). Otherwise the counter increments; when counter==SETTLE_CYCLES-1 -> RUN.
  - RUN: core_rst_n=1, load_done=1. load_en high -> LOADING, core_rst_n=0 on the next edge (registered), and statistics restart as in IDLE.
- core_rst_n and load_done are registered and glitch-free. The first cycle with core_rst_n=1 is SETTLE_CYCLES+1 edges after the edge where load_en was last sampled high.
- Fetch: Inst <= RAM[Inst_addr>>2 mod DEPTH] every clk edge. Low address bits are ignored. No fetch error.
- Same-cycle fetch and load to the same word: Inst returns old data (read-before-write).
- Fetch is also serviced outside RUN; its contents are don't-care to the core, which is held in reset.

Decomposition:
- Shared package: LOAD_ST_IDLE/LOADING/SETTLE/RUN state encodings and INST_W=32.
- One sub-module, inst_ram: single clock, one write port and one registered read port, read-before-write, parameter DEPTH. The FSM, counters, and checksum stay in inst_load_rx.

Test Plan:
- Reset then load words 0x00000013, 0x00100093, 0x00200113 at addresses 0,4,8 on consecutive cycles -> word_cnt=3, checksum=0x003001B9, load_err=0. core_rst_n rises 3 edges after the last load_en. Fetch of 4 returns 0x00100093 one cycle later.
- Load addr 0x6 (misaligned) and addr 0x400 (DEPTH=256) -> load_err=1, word_cnt unchanged, RAM[1] and RAM[0] unmodified.
- Load two words, drop load_en for 1 cycle (< SETTLE_CYCLES=2), load a third -> core_rst_n stays 0 throughout, word_cnt=3.
- In RUN, assert load_en with addr 0 and data 0xDEADBEEF -> core_rst_n=0 next edge, load_done=0, word_cnt=1, checksum=0xDEADBEEF, load_err cleared.
- Same cycle: load addr 8 with 0xAAAA5555 while fetching addr 8 holding 0x11111111 -> Inst=0x11111111 that cycle; 0xAAAA5555 on the next fetch.
- Pull rst_n_mem low in the middle of SETTLE -> all outputs return to reset values asynchronously; RAM keeps the loaded words (checked by fetch after a fresh load/settle).

Source files
------------

// File: rtl/inst_load_rx_pkg.sv
// Shared types for the instruction-load receiver.
// State encodings and the instruction word width.
package inst_load_rx_pkg;

    localparam int INST_W = 32;

    typedef enum logic [1:0] {
        LOAD_ST_IDLE    = 2'd0,
        LOAD_ST_LOADING = 2'd1,
        LOAD_ST_SETTLE  = 2'd2,
        LOAD_ST_RUN     = 2'd3
    } load_st_e;

endpackage

// File: rtl/inst_load_rx_if.sv
// Load port, fetch port and status bundle between loader/core and receiver.
// The master side drives load and fetch requests; the slave side answers.
import inst_load_rx_pkg::*;

interface inst_load_rx_if #(
    parameter int DEPTH = 256,
    parameter int AW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]     Inst_addr_load;
    logic [INST_W-1:0] Inst_load;
    logic              load_en;
    logic [AW-1:0]     Inst_addr;
    logic [INST_W-1:0] Inst;
    logic              core_rst_n;
    logic              load_done;
    logic              load_err;
    logic [CW-1:0]     word_cnt;
    logic [INST_W-1:0] checksum;

    modport master (
        output Inst_addr_load, Inst_load, load_en, Inst_addr,
        input  Inst, core_rst_n, load_done, load_err,
        input  word_cnt, checksum
    );

    modport slave (
        input  Inst_addr_load, Inst_load, load_en, Inst_addr,
        output Inst, core_rst_n, load_done, load_err,
        output word_cnt, checksum
    );

endinterface

// File: rtl/inst_load_rx_ram.sv
// Instruction RAM: one write port, one registered read port.
// A read and write to the same word in one cycle returns the old word.
import inst_load_rx_pkg::*;

module inst_ram #(
    parameter int DEPTH = 256,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IW-1:0]     waddr_i,
    input  logic [INST_W-1:0] wdata_i,
    input  logic [IW-1:0]     raddr_i,
    output logic [INST_W-1:0] rdata_o
);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] rdata_q;

    // Array holds the program image across resets, so it has no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_load_rx.sv
// Instruction-load receiver: program RAM, load statistics, core reset
// sequencing and the core's registered fetch port.
import inst_load_rx_pkg::*;

module inst_load_rx #(
    parameter int DEPTH         = 256,
    parameter int AW            = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n_mem,
    inst_load_rx_if.slave  bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    load_st_e          state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [INST_W-1:0] checksum_q, checksum_d;
    logic              load_err_q, load_err_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              load_done_q, load_done_d;

    logic              in_range;
    logic              aligned;
    logic              wr_ok;
    logic              wr_bad;
    logic              restart;
    logic [INST_W-1:0] rdata;

    generate
        if (AW > IW + 2) begin : g_range
            assign in_range = (bus.Inst_addr_load[AW-1:IW+2] == '0);
        end else begin : g_norange
            assign in_range = 1'b1;
        end
    endgenerate

    assign aligned = (bus.Inst_addr_load[1:0] == 2'b00);
    assign wr_ok   = bus.load_en & aligned & in_range;
    assign wr_bad  = bus.load_en & ~(aligned & in_range);
    assign restart = bus.load_en &
                     ((state_q == LOAD_ST_IDLE) || (state_q == LOAD_ST_RUN));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_cnt_d = word_cnt_q;
        checksum_d = checksum_q;
        load_err_d = load_err_q;

        unique case (state_q)
            LOAD_ST_IDLE, LOAD_ST_RUN: begin
                if (bus.load_en) state_d = LOAD_ST_LOADING;
            end
            LOAD_ST_LOADING: begin
                if (!bus.load_en) begin
                    state_d = LOAD_ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            LOAD_ST_SETTLE: begin
                if (bus.load_en) begin
                    state_d = LOAD_ST_LOADING;
                end else if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = LOAD_ST_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = LOAD_ST_IDLE;
        endcase

        // A new load session counts its first word itself.
        if (restart) begin
            word_cnt_d = wr_ok ? CW'(1) : '0;
            checksum_d = wr_ok ? bus.Inst_load : '0;
            load_err_d = wr_bad;
        end else begin
            if (wr_ok) begin
                if (word_cnt_q != CW'(DEPTH)) word_cnt_d = word_cnt_q + CW'(1);
                checksum_d = checksum_q + bus.Inst_load;
            end
            if (wr_bad) load_err_d = 1'b1;
        end

        core_rst_n_d = (state_d == LOAD_ST_RUN);
        load_done_d  = (state_d == LOAD_ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n_mem) begin
        if (!rst_n_mem) begin
            state_q      <= LOAD_ST_IDLE;
            cnt_q        <= '0;
            word_cnt_q   <= '0;
            checksum_q   <= '0;
            load_err_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_cnt_q   <= word_cnt_d;
            checksum_q   <= checksum_d;
            load_err_q   <= load_err_d;
            core_rst_n_q <= core_rst_n_d;
            load_done_q  <= load_done_d;
        end
    end

    inst_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n_mem),
        .we_i    (wr_ok),
        .waddr_i (bus.Inst_addr_load[IW+1:2]),
        .wdata_i (bus.Inst_load),
        .raddr_i (bus.Inst_addr[IW+1:2]),
        .rdata_o (rdata)
    );

    // Fetch ignores byte-offset and high address bits.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{bus.Inst_addr[AW-1:IW+2], bus.Inst_addr[1:0]};

    assign bus.Inst       = rdata;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;
    assign bus.word_cnt   = word_cnt_q;
    assign bus.checksum   = checksum_q;

endmodule

// File: tb/tb_inst_load_rx.sv
// Directed bench for inst_load_rx with a fetch scoreboard.
module tb_inst_load_rx;

    localparam int DEPTH = 256;
    localparam int AW    = 32;

    typedef struct {
        logic        chk;
        logic [31:0] v;
    } exp_t;

    logic clk;
    logic rst_n_mem;

    int errors;
    int checks;

    logic [31:0] ref_mem [DEPTH];
    logic        ref_vld [DEPTH];
    exp_t        exp_q [$];

    inst_load_rx_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    inst_load_rx #(
        .DEPTH         (DEPTH),
        .AW            (AW),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n_mem (rst_n_mem),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic stat(input logic [31:0] wc, input logic [31:0] cs,
                        input logic err);
        chk("word_cnt", 32'(bus.word_cnt), wc);
        chk("checksum", bus.checksum, cs);
        chk("load_err", 32'(bus.load_err), 32'(err));
    endtask

    task automatic core(input logic rn, input string tag);
        chk({tag, "_core_rst_n"}, 32'(bus.core_rst_n), 32'(rn));
        chk({tag, "_load_done"}, 32'(bus.load_done), 32'(rn));
    endtask

    // One clock: drive load and fetch, advance, compare fetched word.
    task automatic cyc(input logic le, input logic [31:0] la,
                       input logic [31:0] ld, input logic [31:0] fa);
        exp_t e;
        int   fi;
        int   wi;
        bus.load_en        = le;
        bus.Inst_addr_load = la;
        bus.Inst_load      = ld;
        bus.Inst_addr      = fa;
        fi = int'(fa[9:2]);
        e.chk = ref_vld[fi];
        e.v   = ref_mem[fi];
        exp_q.push_back(e);
        if (le && la[1:0] == 2'b00 && la < 32'(DEPTH * 4)) begin
            wi = int'(la[9:2]);
            ref_mem[wi] = ld;
            ref_vld[wi] = 1'b1;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.chk) chk("fetch", bus.Inst, e.v);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
        rst_n_mem          = 1'b0;
        bus.load_en        = 1'b0;
        bus.Inst_addr_load = '0;
        bus.Inst_load      = '0;
        bus.Inst_addr      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inst", bus.Inst, 32'h0);
        stat(0, 0, 1'b0);
        core(1'b0, "rst");
        rst_n_mem = 1'b1;

        // Basic load of three words, then settle.
        cyc(1'b1, 32'h0, 32'h00000013, 32'h0);
        cyc(1'b1, 32'h4, 32'h00100093, 32'h0);
        cyc(1'b1, 32'h8, 32'h00200113, 32'h0);
        stat(3, 32'h003001B9, 1'b0);
        core(1'b0, "load");
        cyc(1'b0, 32'h0, 32'h0, 32'h4);
        core(1'b0, "settle1");
        cyc(1'b0, 32'h0, 32'h0, 32'h8);
        core(1'b0, "settle2");
        cyc(1'b0, 32'h0, 32'h0, 32'h0);
        core(1'b1, "run");

        // Misaligned and out-of-range writes are rejected.
        cyc(1'b1, 32'hC, 32'h00000033, 32'h4);
        stat(1, 32'h33, 1'b0);
        cyc(1'b1, 32'h6, 32'hBAD0BAD0, 32'h4);
        stat(1, 32'h33, 1'b1);
        cyc(1'b1, 32'h400, 32'hBAD1BAD1, 32'h0);
        stat(1, 32'h33, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 32'h4);
        cyc(1'b0, 32'h0, 32'h0, 32'h0);
        cyc(1'b0, 32'h0, 32'h0, 32'hC);
        core(1'b1, "run2");
        chk("err_sticky", 32'(bus.load_err), 32'h1);

        // Reload from RUN restarts stats; read-before-write on word 0.
        cyc(1'b1, 32'h0, 32'hDEADBEEF, 32'h0);
        core(1'b0, "reload");
        stat(1, 32'hDEADBEEF, 1'b0);

        // One-cycle gap shorter than the settle time.
        cyc(1'b1, 32'h10, 32'h1, 32'h0);
        cyc(1'b0, 32'h0, 32'h0, 32'h0);
        core(1'b0, "gap");
        cyc(1'b1, 32'h14, 32'h2, 32'h10);
        core(1'b0, "gap_resume");
        stat(3, 32'hDEADBEF2, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 32'h14);
        core(1'b0, "gap_s1");
        cyc(1'b0, 32'h0, 32'h0, 32'h0);
        core(1'b0, "gap_s2");
        cyc(1'b0, 32'h0, 32'h0, 32'h0);
        core(1'b1, "gap_run");

        // Same-cycle fetch and load of word 2; duplicate address counted.
        cyc(1'b1, 32'h8, 32'h11111111, 32'h0);
        cyc(1'b1, 32'h8, 32'hAAAA5555, 32'h8);
        stat(2, 32'hBBBB6666, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 32'h8);
        core(1'b0, "dup_settle");

        // Asynchronous reset in the middle of SETTLE.
        #2;
        rst_n_mem = 1'b0;
        #1;
        chk("arst_inst", bus.Inst, 32'h0);
        stat(0, 0, 1'b0);
        core(1'b0, "arst");
        @(posedge clk);
        #1;
        rst_n_mem = 1'b1;

        // Fresh load including the top word; RAM kept its image.
        cyc(1'b1, 32'h3FC, 32'h0000005A, 32'h8);
        stat(1, 32'h5A, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 32'hC);
        cyc(1'b0, 32'h0, 32'h0, 32'h3FC);
        cyc(1'b0, 32'h0, 32'h0, 32'h4);
        core(1'b1, "final");
        cyc(1'b0, 32'h0, 32'h0, 32'h10);
        cyc(1'b0, 32'h0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
